// File: rtl/ring_shift_sequencer_if.sv
// ----------------------------------------------------------------------------
// ring_shift_sequencer_if
// Groups the command and pattern handshakes of ring_shift_sequencer.
//   in_valid / in_ready / in_data     : command word in (seed, step count, dir)
//   out_valid / out_ready / out_pattern : rotated ring pattern out
//   busy / done                       : command progress status
// The master modport is the side that issues commands and consumes
// patterns; the slave modport is the sequencer itself.
// ----------------------------------------------------------------------------
interface ring_shift_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_pattern;
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_pattern, busy, done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_pattern, busy, done
  );
endinterface

// File: rtl/ring_shift_sequencer.sv
// ----------------------------------------------------------------------------
// ring_shift_sequencer
// Accepts a command word (seed, step count N, direction) and emits N+1
// 4-bit ring patterns: the seed followed by N single-bit rotations, each
// beat handed over with a valid/ready handshake.  A one-cycle done pulse
// follows the last beat taken.
// Ports:
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   clear    : synchronous abort back to IDLE (no done pulse)
//   bus      : slave side of ring_shift_sequencer_if
// Parameter:
//   RESET_PATTERN : pattern held after reset and after clear
// ----------------------------------------------------------------------------
module ring_shift_sequencer #(
  parameter logic [3:0] RESET_PATTERN = 4'b0001
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  ring_shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_pattern;
  logic [2:0] r_remaining;
  logic       r_dir;
  logic       r_done;
  logic       r_armed;

  logic       w_inReady;
  logic       w_outValid;
  logic       w_accept;
  logic       w_advance;
  logic [3:0] w_rotated;

  // r_armed samples reset_n so that in_ready only rises on the first clock
  // edge after reset is released, rather than the moment reset_n goes high.
  // It needs no reset of its own: while reset_n is low it is masked below.
  always_ff @(posedge clk) begin
    r_armed <= reset_n;
  end

  // dir=1 rotates left (MSB wraps to LSB), dir=0 rotates right.
  assign w_rotated = r_dir ? {r_pattern[2:0], r_pattern[3]}
                           : {r_pattern[0], r_pattern[3:1]};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake decode.  clear overrides both accepting a new
  // command and advancing the current one, so it is applied last.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    w_accept    = 1'b0;
    w_advance   = 1'b0;

    case (r_state)
      IDLE: begin
        w_inReady = reset_n && r_armed && !clear;
        if (bus.in_valid && w_inReady) begin
          w_accept    = 1'b1;
          w_nextState = EMIT;
        end
      end
      EMIT: begin
        w_outValid = 1'b1;
        if (bus.out_ready) begin
          if (r_remaining != 3'd0) begin
            w_advance = 1'b1;
          end else begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (clear) begin
      w_nextState = IDLE;
      w_accept    = 1'b0;
      w_advance   = 1'b0;
    end
  end

  // Pattern datapath.  The pattern only moves on a taken beat, so it stays
  // stable while the consumer stalls, and it holds its last value in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pattern   <= RESET_PATTERN;
      r_remaining <= 3'd0;
      r_dir       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (w_nextState == DONE);
      if (clear) begin
        r_pattern   <= RESET_PATTERN;
        r_remaining <= 3'd0;
      end else if (w_accept) begin
        r_pattern   <= bus.in_data[3:0];
        r_remaining <= bus.in_data[6:4];
        r_dir       <= bus.in_data[7];
      end else if (w_advance) begin
        r_pattern   <= w_rotated;
        r_remaining <= r_remaining - 3'd1;
      end
    end
  end

  assign bus.in_ready    = w_inReady;
  assign bus.out_valid   = w_outValid;
  assign bus.out_pattern = r_pattern;
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;

endmodule

// File: tb/tb_ring_shift_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ring_shift_sequencer
// Directed bench for ring_shift_sequencer with hand-computed pattern
// sequences.  Inputs change 1 ns after a rising edge; outputs are sampled
// there too, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_ring_shift_sequencer;

  logic clk;
  logic reset_n;
  logic clear;

  int assertCount;
  int failCount;

  ring_shift_sequencer_if ifc ();

  ring_shift_sequencer #(
    .RESET_PATTERN (4'b0001)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (ifc.slave)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-run time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] time limit");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; in_ready is expected high beforehand.
  task automatic applyStimulus(input string name, input logic [7:0] cmd);
    checkOutput($sformatf("%s in_ready before accept", name), 32'(ifc.in_ready), 32'd1);
    ifc.in_valid = 1'b1;
    ifc.in_data  = cmd;
    tick();
    ifc.in_valid = 1'b0;
  endtask

  // Runs one full command and checks every beat, the done pulse and the
  // return to IDLE.  expWord holds the expected patterns, beat 0 in the
  // low nibble.  With stall set, out_ready is randomised (first cycle forced
  // low) and the held pattern is rechecked on every stalled cycle.
  task automatic runCommand(input string name, input logic [7:0] cmd,
                            input int nBeats, input logic [31:0] expWord,
                            input bit stall);
    int beat;
    int cycles;
    logic [3:0] expPat;
    applyStimulus(name, cmd);
    beat   = 0;
    cycles = 0;
    while (beat < nBeats && cycles < 200) begin
      expPat = expWord[4*beat +: 4];
      if (stall) begin
        ifc.out_ready = (cycles == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        ifc.out_ready = 1'b1;
      end
      checkOutput($sformatf("%s beat%0d out_valid", name, beat), 32'(ifc.out_valid), 32'd1);
      checkOutput($sformatf("%s beat%0d out_pattern", name, beat), 32'(ifc.out_pattern), 32'(expPat));
      checkOutput($sformatf("%s beat%0d done", name, beat), 32'(ifc.done), 32'd0);
      if (ifc.out_ready) beat++;
      cycles++;
      tick();
    end
    checkOutput($sformatf("%s beats taken within budget", name), 32'(beat), 32'(nBeats));
    ifc.out_ready = 1'b1;
    checkOutput($sformatf("%s done pulse", name), 32'(ifc.done), 32'd1);
    checkOutput($sformatf("%s DONE out_valid", name), 32'(ifc.out_valid), 32'd0);
    checkOutput($sformatf("%s DONE in_ready", name), 32'(ifc.in_ready), 32'd0);
    checkOutput($sformatf("%s DONE busy", name), 32'(ifc.busy), 32'd1);
    tick();
    checkOutput($sformatf("%s done cleared", name), 32'(ifc.done), 32'd0);
    checkOutput($sformatf("%s IDLE in_ready", name), 32'(ifc.in_ready), 32'd1);
    checkOutput($sformatf("%s IDLE busy", name), 32'(ifc.busy), 32'd0);
    checkOutput($sformatf("%s pattern held", name), 32'(ifc.out_pattern),
                32'(expWord[4*(nBeats-1) +: 4]));
  endtask

  initial begin
    assertCount   = 0;
    failCount     = 0;
    reset_n       = 1'b0;
    clear         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = 8'h00;
    ifc.out_ready = 1'b1;

    // Reset state with the clock running.
    #1;
    repeat (3) tick();
    checkOutput("reset in_ready", 32'(ifc.in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(ifc.out_valid), 32'd0);
    checkOutput("reset busy", 32'(ifc.busy), 32'd0);
    checkOutput("reset done", 32'(ifc.done), 32'd0);
    checkOutput("reset out_pattern", 32'(ifc.out_pattern), 32'h1);

    // in_ready stays low until the first edge after release.
    reset_n = 1'b1;
    #1;
    checkOutput("release in_ready before edge", 32'(ifc.in_ready), 32'd0);
    tick();
    checkOutput("release in_ready after edge", 32'(ifc.in_ready), 32'd1);

    // Left, N=3: 0001 0010 0100 1000.
    runCommand("left3", 8'b1_011_0001, 4, 32'h0000_8421, 1'b0);
    // Right, N=2: 0001 1000 0100.
    runCommand("right2", 8'b0_010_0001, 3, 32'h0000_0481, 1'b0);
    // N=0: seed only.
    runCommand("single", 8'b0_000_1010, 1, 32'h0000_000A, 1'b0);
    // Left, N=7 with random stalls: 0011 0110 1100 1001 repeated.
    runCommand("stall7", 8'b1_111_0011, 8, 32'h9C63_9C63, 1'b1);
    // All-zero seed stays zero.
    runCommand("zero", 8'b1_010_0000, 3, 32'h0000_0000, 1'b0);

    // clear on the second beat aborts with no done pulse.
    applyStimulus("clr", 8'b1_011_0001);
    ifc.out_ready = 1'b1;
    checkOutput("clr beat0 pattern", 32'(ifc.out_pattern), 32'h1);
    tick();
    checkOutput("clr beat1 pattern", 32'(ifc.out_pattern), 32'h2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    checkOutput("clr busy", 32'(ifc.busy), 32'd0);
    checkOutput("clr out_valid", 32'(ifc.out_valid), 32'd0);
    checkOutput("clr out_pattern", 32'(ifc.out_pattern), 32'h1);
    checkOutput("clr done", 32'(ifc.done), 32'd0);
    checkOutput("clr in_ready", 32'(ifc.in_ready), 32'd1);
    tick();
    checkOutput("clr no late done", 32'(ifc.done), 32'd0);

    // clear beats a simultaneous accept.
    clear        = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'b1_001_0110;
    #1;
    checkOutput("clr-accept in_ready", 32'(ifc.in_ready), 32'd0);
    tick();
    clear        = 1'b0;
    ifc.in_valid = 1'b0;
    #1;
    checkOutput("clr-accept busy", 32'(ifc.busy), 32'd0);
    checkOutput("clr-accept out_valid", 32'(ifc.out_valid), 32'd0);
    checkOutput("clr-accept out_pattern", 32'(ifc.out_pattern), 32'h1);

    // Asynchronous reset mid-EMIT.
    applyStimulus("rst", 8'b0_010_0001);
    tick();
    checkOutput("rst beat1 pattern", 32'(ifc.out_pattern), 32'h8);
    reset_n = 1'b0;
    #1;
    checkOutput("rst async out_pattern", 32'(ifc.out_pattern), 32'h1);
    checkOutput("rst async out_valid", 32'(ifc.out_valid), 32'd0);
    checkOutput("rst async busy", 32'(ifc.busy), 32'd0);
    checkOutput("rst async in_ready", 32'(ifc.in_ready), 32'd0);
    checkOutput("rst async done", 32'(ifc.done), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    checkOutput("rst release in_ready before edge", 32'(ifc.in_ready), 32'd0);
    tick();
    checkOutput("rst release in_ready after edge", 32'(ifc.in_ready), 32'd1);
    checkOutput("rst no done", 32'(ifc.done), 32'd0);

    // in_valid held high across a command: the first command runs intact,
    // the changed in_data is ignored until IDLE, then accepted right after done.
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 8'b1_001_0101;
    tick();
    checkOutput("hold beat0 pattern", 32'(ifc.out_pattern), 32'h5);
    checkOutput("hold beat0 in_ready", 32'(ifc.in_ready), 32'd0);
    ifc.in_data = 8'b0_000_1110;
    tick();
    checkOutput("hold beat1 pattern", 32'(ifc.out_pattern), 32'hA);
    tick();
    checkOutput("hold done", 32'(ifc.done), 32'd1);
    checkOutput("hold DONE in_ready", 32'(ifc.in_ready), 32'd0);
    checkOutput("hold DONE pattern", 32'(ifc.out_pattern), 32'hA);
    tick();
    checkOutput("hold IDLE in_ready", 32'(ifc.in_ready), 32'd1);
    checkOutput("hold IDLE busy", 32'(ifc.busy), 32'd0);
    tick();
    ifc.in_valid = 1'b0;
    checkOutput("hold second out_valid", 32'(ifc.out_valid), 32'd1);
    checkOutput("hold second pattern", 32'(ifc.out_pattern), 32'hE);
    tick();
    checkOutput("hold second done", 32'(ifc.done), 32'd1);
    tick();
    checkOutput("hold final busy", 32'(ifc.busy), 32'd0);
    checkOutput("hold final done", 32'(ifc.done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ring_shift_sequencer.md
RING_SHIFT_SEQUENCER -- requirements
Module: ring_shift_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PATTERN, default 4'b0001, giving the pattern value held after reset and after clear.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port clear, input, 1 bit, synchronous abort to IDLE.
REQ-005 The block SHALL have port in_valid, input, 1 bit, command word present.
REQ-006 The block SHALL have port in_ready, output, 1 bit, block accepts a command this cycle.
REQ-007 The block SHALL have port in_data, input, 8 bits, command word: [3:0] seed, [6:4] step count N (0-7), [7] direction (1 = left, 0 = right).
REQ-008 The block SHALL have port out_valid, output, 1 bit, out_pattern is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, consumer takes out_pattern this cycle.
REQ-010 The block SHALL have port out_pattern, output, 4 bits, current ring pattern.
REQ-011 The block SHALL have port busy, output, 1 bit, a command is in progress (state not IDLE).
REQ-012 The block SHALL have port done, output, 1 bit, one-cycle pulse after the last pattern of a command is taken.

Function
REQ-013 The FSM SHALL have three states: IDLE, EMIT and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE with clear=0; a command is accepted when in_valid && in_ready.
REQ-015 On accept, the block SHALL load pattern<=in_data[3:0], remaining<=in_data[6:4] and dir<=in_data[7], and enter EMIT on the next cycle.
REQ-016 In EMIT, out_valid SHALL be 1 and out_pattern SHALL be the registered pattern; out_pattern SHALL be stable while out_valid && !out_ready.
REQ-017 In EMIT with out_ready=1 and remaining!=0, the next pattern SHALL be {p[2:0],p[3]} if dir=1 or {p[0],p[3:1]} if dir=0, with remaining decremented by 1 and the state staying EMIT.
REQ-018 In EMIT with out_ready=1 and remaining==0, the state SHALL go to DONE and pattern SHALL hold.
REQ-019 A command with step count N SHALL emit exactly N+1 patterns: the seed followed by N rotations; N=0 emits the seed only.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, out_valid=0 and in_ready=0, and the state SHALL then go to IDLE.
REQ-021 Minimum command-to-command spacing SHALL be N+3 cycles: accept, N+1 EMIT beats with out_ready held 1, then DONE.
REQ-022 An all-zero seed SHALL be legal and rotate to 0000 on every step.
REQ-023 in_valid in states other than IDLE SHALL be ignored; the command is not stored.
REQ-024 clear=1 SHALL, on the next edge from any state, force IDLE, pattern<=RESET_PATTERN and remaining<=0, with no done pulse.
REQ-025 clear SHALL take priority over accept and over advance in the same cycle.
REQ-026 busy SHALL be 1 in EMIT and DONE and 0 in IDLE.

Reset
REQ-027 While reset_n=0, outputs SHALL be in_ready=0, out_valid=0, busy=0, done=0 and out_pattern=RESET_PATTERN, with the state at IDLE.
REQ-028 Assertion of reset_n=0 mid-command SHALL abort immediately without waiting for a clock edge, and no done pulse SHALL follow.
REQ-029 in_ready SHALL rise on the first clk edge after reset_n deasserts.
REQ-030 The only asynchronously reset flops SHALL be the state, pattern, remaining, dir and done flops.

Verification
REQ-031 The bench SHALL drive in_data=8'b1_011_0001 with out_ready=1 and check out_pattern sequence 0001, 0010, 0100, 1000 on consecutive beats, then done=1 for one cycle, then in_ready=1.
REQ-032 The bench SHALL drive in_data=8'b0_010_0001 and check the sequence 0001, 1000, 0100, then done.
REQ-033 The bench SHALL drive in_data=8'b0_000_1010 and check a single beat 1010 followed immediately by done.
REQ-034 The bench SHALL drive in_data=8'b1_111_0011 while toggling out_ready randomly and check 8 beats ending at 1001, with no pattern skipped or repeated and out_pattern stable during stalls.
REQ-035 The bench SHALL pulse clear on the second EMIT beat and check IDLE, out_pattern=0001 and no done pulse; a separate run SHALL pulse reset_n low mid-EMIT and check outputs at reset values before the next edge.
REQ-036 The bench SHALL hold in_valid=1 throughout a command and check that only one command is accepted per IDLE visit and that the next command is accepted on the cycle after done.
